// File: rtl/qft_butterfly_pipe_if.sv
// Handshake bundle for qft_butterfly_pipe: butterfly input side, result side and completion count.
// Latency: none, wires only.
// Backpressure: in_ready/out_ready follow valid-ready semantics; the master drives in_* and out_ready.
interface qft_butterfly_pipe_if #(
  parameter int TOTAL_BITS = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [2*TOTAL_BITS-1:0] in_a;
  logic [2*TOTAL_BITS-1:0] in_b;
  logic [2*TOTAL_BITS-1:0] in_w;
  logic [3:0]              in_tag;
  logic                    out_valid;
  logic                    out_ready;
  logic [2*TOTAL_BITS-1:0] out_p;
  logic [2*TOTAL_BITS-1:0] out_q;
  logic [3:0]              out_tag;
  logic [7:0]              done_count;

  modport master (
    output in_valid, in_a, in_b, in_w, in_tag, out_ready,
    input  in_ready, out_valid, out_p, out_q, out_tag, done_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_w, in_tag, out_ready,
    output in_ready, out_valid, out_p, out_q, out_tag, done_count
  );
endinterface

// File: rtl/qft_butterfly_pipe.sv
// Radix-2 QFT butterfly on S3.4 complex values: p = (a + w*b)*SCALE, q = (a - w*b)*SCALE.
// Latency: 2 cycles (stage 1 holds t = w*b and a, stage 2 holds p/q), one butterfly per cycle.
// Backpressure: both stages freeze while out_valid && !out_ready; in_ready = !out_valid || out_ready.
// Optional macro QFT_BUTTERFLY_SAT_EN: saturating reductions instead of two's-complement wrap.
module qft_butterfly_pipe #(
  parameter int                            TOTAL_BITS = 8,
  parameter int                            FX_BITS    = 4,
  parameter logic signed [TOTAL_BITS-1:0]  SCALE      = 8'sd11
) (
  input logic                 clk,
  input logic                 rst,
  qft_butterfly_pipe_if.slave bus
);
  localparam int TB = TOTAL_BITS;
  localparam int WB = 2 * TOTAL_BITS;

  typedef logic signed [TB-1:0] fx_t;
  typedef logic signed [TB:0]   sum_t;
  typedef logic signed [WB-1:0] wide_t;

  localparam wide_t SAT_MAX = wide_t'((1 << (TB - 1)) - 1);
  localparam wide_t SAT_MIN = wide_t'(-(1 << (TB - 1)));

  // Narrow an intermediate back to one component: clamp when saturating, else keep low bits.
  function automatic fx_t reduce(input wide_t v);
`ifdef QFT_BUTTERFLY_SAT_EN
    if (v > SAT_MAX) begin
      reduce = fx_t'(SAT_MAX);
    end else if (v < SAT_MIN) begin
      reduce = fx_t'(SAT_MIN);
    end else begin
      reduce = fx_t'(v);
    end
`else
    reduce = fx_t'(v);
`endif
  endfunction

  // Full-width signed product, rescaled by the fractional bits, then reduced.
  function automatic fx_t fx_mul(input fx_t x, input fx_t y);
    wide_t prod;
    prod   = wide_t'(x) * wide_t'(y);
    fx_mul = reduce(prod >>> FX_BITS);
  endfunction

  // One-bit-wider add/sub so the carry is visible to the reduction.
  function automatic fx_t fx_add(input fx_t x, input fx_t y);
    sum_t s;
    s      = sum_t'(x) + sum_t'(y);
    fx_add = reduce(wide_t'(s));
  endfunction

  function automatic fx_t fx_sub(input fx_t x, input fx_t y);
    sum_t s;
    s      = sum_t'(x) - sum_t'(y);
    fx_sub = reduce(wide_t'(s));
  endfunction

  logic          en;
  logic          s1_vld_q, s1_vld_d;
  logic [WB-1:0] s1_t_q,   s1_t_d;
  logic [WB-1:0] s1_a_q,   s1_a_d;
  logic [3:0]    s1_tag_q, s1_tag_d;
  logic          out_vld_q, out_vld_d;
  logic [WB-1:0] out_p_q,   out_p_d;
  logic [WB-1:0] out_q_q,   out_q_d;
  logic [3:0]    out_tag_q, out_tag_d;
  logic [7:0]    done_cnt_q, done_cnt_d;

  fx_t b_re, b_im, w_re, w_im, t_re, t_im;
  fx_t a_re, a_im, s1t_re, s1t_im;
  fx_t p_re, p_im, q_re, q_im;

  // Butterfly arithmetic for both stages and the stall-aware next-state selection.
  always_comb begin
    en = !out_vld_q || bus.out_ready;

    b_re = $signed(bus.in_b[WB-1:TB]);
    b_im = $signed(bus.in_b[TB-1:0]);
    w_re = $signed(bus.in_w[WB-1:TB]);
    w_im = $signed(bus.in_w[TB-1:0]);
    t_re = fx_sub(fx_mul(w_re, b_re), fx_mul(w_im, b_im));
    t_im = fx_add(fx_mul(w_re, b_im), fx_mul(w_im, b_re));

    a_re   = $signed(s1_a_q[WB-1:TB]);
    a_im   = $signed(s1_a_q[TB-1:0]);
    s1t_re = $signed(s1_t_q[WB-1:TB]);
    s1t_im = $signed(s1_t_q[TB-1:0]);
    p_re   = fx_mul(fx_add(a_re, s1t_re), SCALE);
    p_im   = fx_mul(fx_add(a_im, s1t_im), SCALE);
    q_re   = fx_mul(fx_sub(a_re, s1t_re), SCALE);
    q_im   = fx_mul(fx_sub(a_im, s1t_im), SCALE);

    s1_vld_d   = s1_vld_q;
    s1_t_d     = s1_t_q;
    s1_a_d     = s1_a_q;
    s1_tag_d   = s1_tag_q;
    out_vld_d  = out_vld_q;
    out_p_d    = out_p_q;
    out_q_d    = out_q_q;
    out_tag_d  = out_tag_q;
    done_cnt_d = done_cnt_q;

    if (en) begin
      // Stage 1 takes a new butterfly, or becomes a bubble when nothing is offered.
      s1_vld_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_t_d   = {t_re, t_im};
        s1_a_d   = bus.in_a;
        s1_tag_d = bus.in_tag;
      end
      // Stage 2 data only changes when a real butterfly moves in, so a drained output keeps its last value.
      out_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        out_p_d   = {p_re, p_im};
        out_q_d   = {q_re, q_im};
        out_tag_d = s1_tag_q;
      end
    end

    if (out_vld_q && bus.out_ready) begin
      done_cnt_d = done_cnt_q + 8'd1;
    end
  end

  // Pipeline registers; reset discards anything in flight, stalled or not.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s1_t_q     <= '0;
      s1_a_q     <= '0;
      s1_tag_q   <= '0;
      out_vld_q  <= 1'b0;
      out_p_q    <= '0;
      out_q_q    <= '0;
      out_tag_q  <= '0;
      done_cnt_q <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_t_q     <= s1_t_d;
      s1_a_q     <= s1_a_d;
      s1_tag_q   <= s1_tag_d;
      out_vld_q  <= out_vld_d;
      out_p_q    <= out_p_d;
      out_q_q    <= out_q_d;
      out_tag_q  <= out_tag_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign bus.in_ready   = en;
  assign bus.out_valid  = out_vld_q;
  assign bus.out_p      = out_p_q;
  assign bus.out_q      = out_q_q;
  assign bus.out_tag    = out_tag_q;
  assign bus.done_count = done_cnt_q;
endmodule
